// File: rtl/serial_fa_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the operand-width legality rule.
package serial_fa_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_fa_ctrl_fa.sv
// One-bit full adder cell; the only arithmetic element of the serial adder.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_fa_ctrl.sv
// Bit-serial adder: one full adder is reused WIDTH times, LSB first, between
// a valid/ready operand source and a valid/ready result sink.
module serial_fa_ctrl
  import serial_fa_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("serial_fa_ctrl: WIDTH must be within 2..32");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             inc_c;
  logic             fa_sum, fa_cout;

  fa u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    inc_c       = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_HOLD;
        end else begin
          // Ripple increment kept bitwise so the full adder stays the only adder.
          for (int i = 0; i < CW; i++) begin
            cnt_d[i] = cnt_q[i] ^ inc_c;
            inc_c    = cnt_q[i] & inc_c;
          end
        end
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake flags are pure functions of state, registered to cut any
    // input-to-ready/valid combinational path.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_q == ST_HOLD) && (state_d == ST_HOLD);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_serial_fa_ctrl.sv
// Scoreboard bench for serial_fa_ctrl: expected sums come from plain integer
// addition; a monitor pops and compares on every result transfer.
module tb_serial_fa_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;

  int n_tests  = 0;
  int n_fail   = 0;
  int n_issued = 0;
  int n_xfer   = 0;

  logic [W:0] sb[$];
  bit         rand_rdy  = 1'b0;
  logic       rdy_force = 1'b0;

  always #5 clk = ~clk;

  serial_fa_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sink readiness changes just after the rising edge.
  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // Monitor: compares each transfer and checks HOLD stability.
  logic [W:0] prev;
  bit         prev_hold = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("out_valid_held", {31'b0, out_valid}, 32'd1);
        check("hold_stable", {23'b0, cout, sum}, {23'b0, prev});
      end
      prev_hold = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            check("no_spurious_result", {31'b0, out_valid}, 32'd0);
          end else begin
            check("result", {23'b0, cout, sum}, {23'b0, sb.pop_front()});
            n_xfer++;
          end
        end else begin
          prev_hold = 1'b1;
          prev      = {cout, sum};
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    int n = 0;
    @(negedge clk);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", {31'b0, in_ready}, 32'd1);
    end else begin
      sb.push_back((W+1)'(av) + (W+1)'(bv) + (W+1)'(cv));
      n_issued++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_sum"}, {24'b0, sum}, 32'd0);
    check({tag, "_cout"}, {31'b0, cout}, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle_outputs("quiet");
    end

    // Basic add with latency measurement.
    rdy_force = 1'b1;
    send(8'h3C, 8'h42, 1'b0);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) check("in_ready_busy", {31'b0, in_ready}, 32'd0);
    end while (!out_valid && k < 30);
    check("latency", k, 32'd9);
    @(posedge clk);
    #1;
    check("in_ready_after_xfer", {31'b0, in_ready}, 32'd1);
    check("out_valid_after_xfer", {31'b0, out_valid}, 32'd0);

    // Carry ripple across every bit.
    send(8'hFF, 8'h01, 1'b0);
    send(8'hA5, 8'h5A, 1'b1);
    drain(100);

    // Backpressure with operand pulses during HOLD.
    rdy_force = 1'b0;
    @(negedge clk);
    send(8'h80, 8'h80, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_reach_hold", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      in_valid = (i % 2 == 0);
      @(negedge clk);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_sum", {24'b0, sum}, 32'h01);
      check("bp_cout", {31'b0, cout}, 32'd1);
    end
    // out_ready and in_valid together in HOLD: only the result moves.
    in_valid  = 1'b1;
    rdy_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_idle_in_ready", {31'b0, in_ready}, 32'd1);
    check("bp_idle_out_valid", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("bp_not_consumed", {31'b0, out_valid}, 32'd0);
    end
    check("bp_queue_empty", sb.size(), 32'd0);

    // Reset in the middle of an operation.
    send(8'h0F, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    n_issued -= sb.size();
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h01, 8'h01, 1'b0);
    drain(100);

    // Randomised traffic under random sink readiness.
    rand_rdy = 1'b1;
    for (int c = 0; c < 2; c++) begin
      for (int av = 0; av < 256; av++) begin
        send(W'(av), W'($urandom), 1'(c));
      end
    end
    for (int i = 0; i < 1000; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom));
    end
    drain(500);
    check("xfer_count", n_xfer, n_issued);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
